program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 213 +++++++++++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: streams host instruction words into instruction memory,
// holds the CPU in reset for a fixed number of cycles, releases it to run under
// a cycle watchdog, then requests a memory dump when the CPU signals it is done.
module program_loader #(
  parameter int IM_DEPTH   = 512,
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 65536
) (
  input  logic                         clk,
  input  logic                         ldrRstN,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         wordValid,
  input  logic [31:0]                  wordData,
  input  logic                         wordLast,
  output logic                         wordReady,
  output logic                         imWrEn,
  output logic [31:0]                  imAddr,
  output logic [31:0]                  imWrData,
  output logic                         cpuRst,
  output logic                         insEn,
  output logic                         dmEn,
  output logic                         printmem,
  input  logic                         EndProgram,
  output logic                         done,
  output logic [1:0]                   err,
  output logic [$clog2(IM_DEPTH):0]    wordCount,
  output logic [31:0]                  cycleCount
);

  localparam int WC_W = $clog2(IM_DEPTH) + 1;

  localparam logic [WC_W-1:0] WC_FULL   = WC_W'(IM_DEPTH);
  localparam logic [3:0]      HOLD_LAST = 4'(RST_HOLD - 1);
  localparam logic [31:0]     CYC_LAST  = 32'(MAX_CYCLES - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DUMP,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic [1:0]      err_q, err_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;

  logic            room;
  logic            xfer;

  // Saturating increment of the loaded-word counter.
  function automatic logic [WC_W-1:0] sat_inc_wc(input logic [WC_W-1:0] v);
    if (v == {WC_W{1'b1}}) begin
      return v;
    end
    return v + WC_W'(1);
  endfunction

  // Saturating increment of the run-cycle counter.
  function automatic logic [31:0] sat_inc_cyc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end
    return v + 32'd1;
  endfunction

  // State and counter registers; reset lands in IDLE with everything cleared.
  always_ff @(posedge clk or negedge ldrRstN) begin
    if (!ldrRstN) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      err_q       <= ERR_NONE;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    hold_cnt_d  = hold_cnt_q;

    wordReady   = 1'b0;
    imWrEn      = 1'b0;
    imAddr      = '0;
    imWrData    = '0;
    cpuRst      = 1'b1;
    insEn       = 1'b0;
    dmEn        = 1'b0;
    printmem    = 1'b0;
    done        = 1'b0;

    room        = (word_cnt_q < WC_FULL);
    xfer        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          err_d       = ERR_NONE;
        end
      end

      S_LOAD: begin
        wordReady = room;
        xfer      = wordValid & room;
        if (xfer) begin
          imWrEn     = 1'b1;
          imAddr     = {30'(word_cnt_q), 2'b00};
          imWrData   = wordData;
          word_cnt_d = sat_inc_wc(word_cnt_q);
          if (wordLast) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end
        end else if (wordValid) begin
          // Memory full and the host still has a word: overflow, nothing written.
          state_d = S_ERR;
          err_d   = ERR_OVF;
        end
      end

      S_HOLD: begin
        if (hold_cnt_q >= HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      S_RUN: begin
        cpuRst      = 1'b0;
        insEn       = 1'b1;
        dmEn        = 1'b1;
        cycle_cnt_d = sat_inc_cyc(cycle_cnt_q);
        // A CPU finishing on the watchdog's last cycle still counts as a normal end.
        if (EndProgram) begin
          state_d = S_DUMP;
        end else if (cycle_cnt_q == CYC_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_TMO;
        end
      end

      S_DUMP: begin
        cpuRst   = 1'b0;
        insEn    = 1'b1;
        dmEn     = 1'b1;
        printmem = 1'b1;
        state_d  = S_DONE;
      end

      S_DONE: begin
        // CPU is left out of reset so its state can be inspected.
        cpuRst = 1'b0;
        done   = 1'b1;
        if (start) begin
          state_d     = S_LOAD;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          err_d       = ERR_NONE;
        end
      end

      S_ERR: begin
        if (start) begin
          state_d     = S_LOAD;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          err_d       = ERR_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition and leaves a clean IDLE behind.
    if (abort) begin
      state_d     = S_IDLE;
      word_cnt_d  = '0;
      cycle_cnt_d = '0;
      err_d       = ERR_NONE;
      hold_cnt_d  = '0;
    end
  end

  assign err        = err_q;
  assign wordCount  = word_cnt_q;
  assign cycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-parameter instance and a small
// instance (IM_DEPTH=4, MAX_CYCLES=16) share one stimulus stream.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        ldrRstN, start, abort, wordValid, wordLast, EndProgram;
  logic [31:0] wordData;

  logic        d_wordReady, d_imWrEn, d_cpuRst, d_insEn, d_dmEn, d_printmem, d_done;
  logic [31:0] d_imAddr, d_imWrData, d_cycleCount;
  logic [1:0]  d_err;
  logic [9:0]  d_wordCount;

  logic        s_wordReady, s_imWrEn, s_cpuRst, s_insEn, s_dmEn, s_printmem, s_done;
  logic [31:0] s_imAddr, s_imWrData, s_cycleCount;
  logic [1:0]  s_err;
  logic [2:0]  s_wordCount;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [31:0] w [3] = '{32'h2008_0005, 32'h2009_0003, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  program_loader u_dut (
    .clk(clk), .ldrRstN(ldrRstN), .start(start), .abort(abort),
    .wordValid(wordValid), .wordData(wordData), .wordLast(wordLast),
    .wordReady(d_wordReady), .imWrEn(d_imWrEn), .imAddr(d_imAddr),
    .imWrData(d_imWrData), .cpuRst(d_cpuRst), .insEn(d_insEn), .dmEn(d_dmEn),
    .printmem(d_printmem), .EndProgram(EndProgram), .done(d_done),
    .err(d_err), .wordCount(d_wordCount), .cycleCount(d_cycleCount)
  );

  program_loader #(.IM_DEPTH(4), .RST_HOLD(2), .MAX_CYCLES(16)) u_small (
    .clk(clk), .ldrRstN(ldrRstN), .start(start), .abort(abort),
    .wordValid(wordValid), .wordData(wordData), .wordLast(wordLast),
    .wordReady(s_wordReady), .imWrEn(s_imWrEn), .imAddr(s_imAddr),
    .imWrData(s_imWrData), .cpuRst(s_cpuRst), .insEn(s_insEn), .dmEn(s_dmEn),
    .printmem(s_printmem), .EndProgram(EndProgram), .done(s_done),
    .err(s_err), .wordCount(s_wordCount), .cycleCount(s_cycleCount)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ldrRstN = 1'b0; start = 1'b0; abort = 1'b0; wordValid = 1'b0;
    wordLast = 1'b0; wordData = '0; EndProgram = 1'b0;
    #2;
    chk("rst_cpuRst",     32'(d_cpuRst), 32'd1);
    chk("rst_wordReady",  32'(d_wordReady), 32'd0);
    chk("rst_imWrEn",     32'(d_imWrEn), 32'd0);
    chk("rst_insEn",      32'(d_insEn), 32'd0);
    chk("rst_dmEn",       32'(d_dmEn), 32'd0);
    chk("rst_printmem",   32'(d_printmem), 32'd0);
    chk("rst_done",       32'(d_done), 32'd0);
    chk("rst_err",        32'(d_err), 32'd0);
    chk("rst_wordCount",  32'(d_wordCount), 32'd0);
    chk("rst_cycleCount", d_cycleCount, 32'd0);
    chk("rst_imAddr",     d_imAddr, 32'd0);
    cyc(); cyc();
    ldrRstN = 1'b1;
    cyc();

    // Three-word load, hold, run ten cycles, dump, done
    start = 1'b1; cyc(); start = 1'b0; #1;
    chk("ld_wordReady", 32'(d_wordReady), 32'd1);
    chk("ld_cpuRst",    32'(d_cpuRst), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wordValid = 1'b1; wordData = w[i]; wordLast = (i == 2); #1;
      chk("ld_imWrEn",   32'(d_imWrEn), 32'd1);
      chk("ld_imAddr",   d_imAddr, 32'(4 * i));
      chk("ld_imWrData", d_imWrData, w[i]);
      cyc();
    end
    wordValid = 1'b0; wordLast = 1'b0; #1;
    chk("hold_wordCount", 32'(d_wordCount), 32'd3);
    chk("hold1_cpuRst",   32'(d_cpuRst), 32'd1);
    chk("hold_wordReady", 32'(d_wordReady), 32'd0);
    chk("hold_imWrEn",    32'(d_imWrEn), 32'd0);
    cyc(); #1;
    chk("hold2_cpuRst", 32'(d_cpuRst), 32'd1);
    chk("hold2_insEn",  32'(d_insEn), 32'd0);
    cyc(); #1;
    chk("run_cpuRst",     32'(d_cpuRst), 32'd0);
    chk("run_insEn",      32'(d_insEn), 32'd1);
    chk("run_dmEn",       32'(d_dmEn), 32'd1);
    chk("run_cycleCount", d_cycleCount, 32'd0);
    repeat (9) cyc();
    #1;
    chk("run10_cycleCount", d_cycleCount, 32'd9);
    EndProgram = 1'b1; #1;
    chk("run10_printmem", 32'(d_printmem), 32'd0);
    cyc();
    EndProgram = 1'b0; #1;
    chk("dump_printmem",   32'(d_printmem), 32'd1);
    chk("dump_insEn",      32'(d_insEn), 32'd1);
    chk("dump_cpuRst",     32'(d_cpuRst), 32'd0);
    chk("dump_cycleCount", d_cycleCount, 32'd10);
    cyc(); #1;
    chk("done_done",       32'(d_done), 32'd1);
    chk("done_printmem",   32'(d_printmem), 32'd0);
    chk("done_insEn",      32'(d_insEn), 32'd0);
    chk("done_dmEn",       32'(d_dmEn), 32'd0);
    chk("done_cpuRst",     32'(d_cpuRst), 32'd0);
    chk("done_cycleCount", d_cycleCount, 32'd10);
    chk("done_wordCount",  32'(d_wordCount), 32'd3);

    // Valid toggling every other cycle; a lone wordLast without valid is ignored
    start = 1'b1; cyc(); start = 1'b0; #1;
    chk("ld2_wordCount",  32'(d_wordCount), 32'd0);
    chk("ld2_cycleCount", d_cycleCount, 32'd0);
    chk("ld2_done",       32'(d_done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wordValid = (k % 2 == 0);
      wordLast  = (k == 1) || (k == 4);
      wordData  = 32'hA000_0000 + 32'(k);
      #1;
      chk("tg_imWrEn", 32'(d_imWrEn), 32'(k % 2 == 0));
      if (k % 2 == 0) chk("tg_imAddr", d_imAddr, 32'(4 * (k / 2)));
      cyc();
    end
    wordValid = 1'b0; wordLast = 1'b0; #1;
    chk("tg_wordCount", 32'(d_wordCount), 32'd3);
    chk("tg_wordReady", 32'(d_wordReady), 32'd0);

    // Abort during HOLD
    abort = 1'b1; cyc(); abort = 1'b0; #1;
    chk("ab_cpuRst",    32'(d_cpuRst), 32'd1);
    chk("ab_wordCount", 32'(d_wordCount), 32'd0);
    chk("ab_wordReady", 32'(d_wordReady), 32'd0);
    chk("ab_insEn",     32'(d_insEn), 32'd0);
    repeat (3) cyc();
    #1;
    chk("ab_idle_insEn",  32'(d_insEn), 32'd0);
    chk("ab_idle_cpuRst", 32'(d_cpuRst), 32'd1);

    // Reset asserted in the middle of the next load
    start = 1'b1; cyc(); start = 1'b0;
    wordValid = 1'b1; wordData = 32'h1111_1111; #1;
    chk("ld3_addr0", d_imAddr, 32'd0);
    cyc();
    wordData = 32'h2222_2222; #1;
    chk("ld3_addr4", d_imAddr, 32'd4);
    ldrRstN = 1'b0; #1;
    chk("rst2_imWrEn",    32'(d_imWrEn), 32'd0);
    chk("rst2_wordReady", 32'(d_wordReady), 32'd0);
    chk("rst2_wordCount", 32'(d_wordCount), 32'd0);
    chk("rst2_cpuRst",    32'(d_cpuRst), 32'd1);
    chk("rst2_imAddr",    d_imAddr, 32'd0);
    chk("rst2_imWrData",  d_imWrData, 32'd0);
    cyc(); #1;
    chk("rst2_held_imWrEn", 32'(d_imWrEn), 32'd0);
    ldrRstN = 1'b1; wordValid = 1'b0;
    cyc();

    // Reload restarts at address 0; small instance then runs into its watchdog
    start = 1'b1; cyc(); start = 1'b0;
    wordValid = 1'b1; wordLast = 1'b1; wordData = 32'h3333_3333; #1;
    chk("re_imAddr", d_imAddr, 32'd0);
    chk("re_imWrEn", 32'(d_imWrEn), 32'd1);
    cyc();
    wordValid = 1'b0; wordLast = 1'b0;
    cyc(); cyc(); #1;
    chk("wd_run_insEn",      32'(s_insEn), 32'd1);
    chk("wd_run_cycleCount", s_cycleCount, 32'd0);
    for (int j = 1; j < 16; j++) begin
      cyc(); #1;
      chk("wd_printmem", 32'(s_printmem), 32'd0);
    end
    chk("wd_last_cycleCount", s_cycleCount, 32'd15);
    chk("wd_last_insEn",      32'(s_insEn), 32'd1);
    cyc(); #1;
    chk("wd_err",        32'(s_err), 32'd2);
    chk("wd_cpuRst",     32'(s_cpuRst), 32'd1);
    chk("wd_insEn",      32'(s_insEn), 32'd0);
    chk("wd_cycleCount", s_cycleCount, 32'd16);
    chk("wd_printmem_e", 32'(s_printmem), 32'd0);
    chk("wd_big_insEn",  32'(d_insEn), 32'd1);
    chk("wd_big_err",    32'(d_err), 32'd0);

    // Overflow on the small instance: five words, none marked last
    abort = 1'b1; cyc(); abort = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wordValid = 1'b1; wordData = 32'hB000_0000 + 32'(k); #1;
      if (k < 4) begin
        chk("ov_imWrEn", 32'(s_imWrEn), 32'd1);
        chk("ov_imAddr", s_imAddr, 32'(4 * k));
      end else begin
        chk("ov5_imWrEn",    32'(s_imWrEn), 32'd0);
        chk("ov5_wordReady", 32'(s_wordReady), 32'd0);
        chk("ov5_wordCount", 32'(s_wordCount), 32'd4);
      end
      cyc();
    end
    wordValid = 1'b0; #1;
    chk("ov_err",        32'(s_err), 32'd1);
    chk("ov_cpuRst",     32'(s_cpuRst), 32'd1);
    chk("ov_wordCount",  32'(s_wordCount), 32'd4);
    chk("ov_imWrEn",     32'(s_imWrEn), 32'd0);
    chk("ov_big_wcount", 32'(d_wordCount), 32'd5);

    // wordLast on the final legal word; start is ignored by the loading instance
    start = 1'b1; cyc(); start = 1'b0; #1;
    chk("lt_err_clr",     32'(s_err), 32'd0);
    chk("lt_wcount_clr",  32'(s_wordCount), 32'd0);
    chk("lt_big_ignored", 32'(d_wordCount), 32'd5);
    for (int k = 0; k < 4; k++) begin
      wordValid = 1'b1; wordLast = (k == 3); wordData = 32'hC000_0000 + 32'(k); #1;
      chk("lt_imWrEn",      32'(s_imWrEn), 32'd1);
      chk("lt_big_imAddr",  d_imAddr, 32'(4 * (5 + k)));
      cyc();
    end
    wordValid = 1'b0; wordLast = 1'b0; #1;
    chk("lt_err",        32'(s_err), 32'd0);
    chk("lt_wordCount",  32'(s_wordCount), 32'd4);
    chk("lt_big_wcount", 32'(d_wordCount), 32'd9);
    cyc(); cyc(); #1;
    chk("lt_run_insEn", 32'(s_insEn), 32'd1);

    // EndProgram on the watchdog's final cycle wins
    repeat (15) cyc();
    #1;
    chk("tie_cycleCount", s_cycleCount, 32'd15);
    EndProgram = 1'b1;
    cyc();
    EndProgram = 1'b0; #1;
    chk("tie_printmem", 32'(s_printmem), 32'd1);
    chk("tie_err",      32'(s_err), 32'd0);
    cyc(); #1;
    chk("tie_done", 32'(s_done), 32'd1);
    chk("tie_err2", 32'(s_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
